// File: rtl/sbe_pkg.sv
// Shared constants and helpers for the spectrum bar engine.
package sbe_pkg;

  localparam int unsigned SCREEN_W_DEF = 800;
  localparam int unsigned NUM_BINS_DEF = 10;
  localparam int unsigned BIN_IDX_W    = 5;

  function automatic int unsigned bin_px(input int unsigned screen_w,
                                         input int unsigned num_bins);
    return screen_w / num_bins;
  endfunction

  // Saturating subtract, clamped at zero and masked to w bits.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (a > b) ? ((a - b) & mask) : '0;
  endfunction

endpackage

// File: rtl/spectrum_bar_engine_if.sv
// Bus bundle between the power calculator / VGA timing side and the bar engine.
interface spectrum_bar_engine_if #(
  parameter int unsigned NUM_BINS = 10,
  parameter int unsigned VAL_W    = 12,
  parameter int unsigned POSX_W   = 10
);
  logic [NUM_BINS*VAL_W-1:0] bins_flat;
  logic                      bins_valid;
  logic                      sample_tick;
  logic [15:0]               prescaler_in;
  logic                      prescaler_load;
  logic                      frame_start;
  logic [POSX_W-1:0]         posx;
  logic                      posx_valid;
  logic [15:0]               prescaler;
  logic                      set_values_flag;
  logic [4:0]                bin_idx;
  logic [VAL_W-1:0]          val_out;
  logic [VAL_W-1:0]          peak_out;
  logic                      pix_valid;

  modport master (
    output bins_flat, bins_valid, sample_tick, prescaler_in, prescaler_load,
           frame_start, posx, posx_valid,
    input  prescaler, set_values_flag, bin_idx, val_out, peak_out, pix_valid
  );

  modport slave (
    input  bins_flat, bins_valid, sample_tick, prescaler_in, prescaler_load,
           frame_start, posx, posx_valid,
    output prescaler, set_values_flag, bin_idx, val_out, peak_out, pix_valid
  );
endinterface

// File: rtl/peak_hold_cell.sv
// One bin: committed display value plus peak-hold with timed linear decay.
module peak_hold_cell
  import sbe_pkg::*;
#(
  parameter int unsigned VAL_W       = 12,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned DECAY_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             commit,
  input  logic [VAL_W-1:0] pend_val,
  output logic [VAL_W-1:0] disp_val,
  output logic [VAL_W-1:0] peak_val
);

  logic [VAL_W-1:0] disp_q, disp_d;
  logic [VAL_W-1:0] peak_q, peak_d;
  logic [VAL_W-1:0] decayed_c;
  logic [7:0]       hold_q, hold_d;

  // Peak follows the post-commit display value so it never drops below it.
  always_comb begin
    disp_d    = commit ? pend_val : disp_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    decayed_c = VAL_W'(sat_sub(32'(peak_q), 32'(DECAY_STEP), VAL_W));
    if (frame_start) begin
      if (disp_d >= peak_q) begin
        peak_d = disp_d;
        hold_d = 8'(HOLD_FRAMES);
      end else if (hold_q != 8'd0) begin
        hold_d = hold_q - 8'd1;
      end else begin
        peak_d = (decayed_c > disp_d) ? decayed_c : disp_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      disp_q <= disp_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign disp_val = disp_q;
  assign peak_val = peak_q;

endmodule

// File: rtl/spectrum_bar_engine.sv
// Bar-graph engine: update prescaler, frame-synchronous double buffer,
// per-bin peak hold and a two-stage pixel lookup pipeline.
module spectrum_bar_engine
  import sbe_pkg::*;
#(
  parameter int unsigned NUM_BINS     = NUM_BINS_DEF,
  parameter int unsigned VAL_W        = 12,
  parameter int unsigned POSX_W       = 10,
  parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
  parameter int unsigned PRESCALE_RST = 4096,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DECAY_STEP   = 4
) (
  input logic                  vga_clk,
  input logic                  rst_n,
  spectrum_bar_engine_if.slave bus
);

  localparam int unsigned BIN_PX = bin_px(SCREEN_W, NUM_BINS);
  localparam int unsigned IDX_W  = BIN_IDX_W;
  localparam int unsigned SLOTS  = 2 ** IDX_W;

  logic [15:0] prescaler_q, prescaler_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flag_c;

  logic [NUM_BINS*VAL_W-1:0] pend_q, pend_d;
  logic                      pend_vld_q, pend_vld_d;
  logic                      commit_c;

  logic [VAL_W-1:0] disp_val [SLOTS];
  logic [VAL_W-1:0] peak_val [SLOTS];

  logic [IDX_W-1:0] bin_c;
  logic [IDX_W-1:0] s1_bin_q, s1_bin_d;
  logic             s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0] bin_idx_q, bin_idx_d;
  logic             pix_vld_q, pix_vld_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [VAL_W-1:0] peak_q, peak_d;

  // Prescaler: a load restarts the count and suppresses the flag that cycle.
  always_comb begin
    prescaler_d = prescaler_q;
    cnt_d       = cnt_q;
    flag_c      = 1'b0;
    if (bus.prescaler_load) begin
      prescaler_d = bus.prescaler_in;
      cnt_d       = '0;
    end else if (bus.sample_tick) begin
      if (cnt_q == prescaler_q) begin
        flag_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Pending buffer: commit uses the old contents even if new data lands now.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    commit_c   = bus.frame_start & pend_vld_q;
    if (bus.frame_start) pend_vld_d = 1'b0;
    if (bus.bins_valid) begin
      pend_d     = bus.bins_flat;
      pend_vld_d = 1'b1;
    end
  end

  for (genvar k = 0; k < SLOTS; k++) begin : g_bin
    if (k < NUM_BINS) begin : g_cell
      peak_hold_cell #(
        .VAL_W      (VAL_W),
        .HOLD_FRAMES(HOLD_FRAMES),
        .DECAY_STEP (DECAY_STEP)
      ) u_cell (
        .clk        (vga_clk),
        .rst_n      (rst_n),
        .frame_start(bus.frame_start),
        .commit     (commit_c),
        .pend_val   (pend_q[k*VAL_W +: VAL_W]),
        .disp_val   (disp_val[k]),
        .peak_val   (peak_val[k])
      );
    end else begin : g_tie
      assign disp_val[k] = '0;
      assign peak_val[k] = '0;
    end
  end

  // Compare chain replaces posx / BIN_PX; columns past the last bin clamp.
  always_comb begin
    bin_c = '0;
    for (int unsigned k = 1; k < NUM_BINS; k++) begin
      if (32'(bus.posx) >= k * BIN_PX) bin_c = IDX_W'(k);
    end
    s1_bin_d  = bin_c;
    s1_vld_d  = bus.posx_valid;
    pix_vld_d = s1_vld_q;
    bin_idx_d = bin_idx_q;
    val_d     = '0;
    peak_d    = '0;
    if (s1_vld_q) begin
      bin_idx_d = s1_bin_q;
      val_d     = disp_val[s1_bin_q];
      peak_d    = peak_val[s1_bin_q];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      prescaler_q <= 16'(PRESCALE_RST);
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      s1_bin_q    <= '0;
      s1_vld_q    <= 1'b0;
      bin_idx_q   <= '0;
      pix_vld_q   <= 1'b0;
      val_q       <= '0;
      peak_q      <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      s1_bin_q    <= s1_bin_d;
      s1_vld_q    <= s1_vld_d;
      bin_idx_q   <= bin_idx_d;
      pix_vld_q   <= pix_vld_d;
      val_q       <= val_d;
      peak_q      <= peak_d;
    end
  end

  assign bus.prescaler       = prescaler_q;
  assign bus.set_values_flag = flag_c & rst_n;
  assign bus.bin_idx         = bin_idx_q;
  assign bus.val_out         = val_q;
  assign bus.peak_out        = peak_q;
  assign bus.pix_valid       = pix_vld_q;

endmodule
